pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers: one elastic pipeline stage with valid/ready handshake, a 2-entry skid buffer, synchronous flush and a stall counter.
- Carries a control bundle (zeroed on flush, so a NOP bubble) and a data bundle (held on flush).
- Sits between any two pipeline stages (e.g. decode->execute) so that backpressure replaces global stall enables.

Parameters:
CTRL_W, 16, width of control bundle; all-zero encodes a bubble/NOP
DATA_W, 128, width of data bundle (operands, PC, immediate, register indices)
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of both entries (branch/jump squash)
in_valid  in  1  upstream offers a beat
in_ready  out  1  stage can accept a beat; registered, depends only on state
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  stage presents a beat
out_ready  in  1  downstream accepts the beat
out_ctrl  out  CTRL_W  control of the presented beat; all-zero when out_valid=0
out_data  out  DATA_W  data of the presented beat
occupancy  out  2  number of held entries (0..2)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Each entry holds valid, ctrl and data.
- acc = in_valid & in_ready; pop = out_valid & out_ready.
- State is implied by the valid bits: EMPTY (0 entries), ONE (main only), FULL (main+skid). The skid entry is never valid without main.
- in_ready = (state != FULL). out_valid = main.valid. occupancy = 0/1/2.
- EMPTY:
  - acc -> ONE, main <= in.
  - otherwise stay in EMPTY.
- ONE:
  - acc & pop -> ONE, main <= in.
  - acc & ~pop -> FULL, skid <= in, main unchanged.
  - ~acc & pop -> EMPTY.
  - neither -> hold.
- FULL (acc impossible):
  - pop -> ONE, main <= skid, skid.valid <= 0.
  - otherwise hold.
- Latency: a beat accepted at edge N is presented from cycle N+1 when the stage is EMPTY or is ONE with a simultaneous pop.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Ordering: strict FIFO; no beat is duplicated or dropped except by flush/rst.
- Output stability: while out_valid=1 and out_ready=0, out_ctrl and out_data stay constant.
- flush=1 at an edge:
  - Both valid bits and both ctrl fields go to 0; data fields hold.
  - A simultaneous acc is discarded.
  - A simultaneous pop is still a valid transfer downstream in that cycle.
  - Next cycle: state EMPTY, in_ready=1.
- rst=1 at an edge: same as flush, and additionally both data fields <= 0 and stall_cnt <= 0. rst has priority over flush.
- Reset values of outputs: in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
- Reset mid-operation: all held beats are lost with no partial state. The first post-reset cycle behaves exactly as after power-up reset.
- stall_cnt:
  - Increments by 1 at each edge where out_valid=1 & out_ready=0, and saturates at 2^CNT_W-1.
  - Cleared only by rst; flush does not clear it.
- out_ctrl gating: the output is forced to 0 whenever main.valid=0, independent of stored ctrl bits.
- No combinational path from out_ready to in_ready, nor from in_valid to out_valid.

Test Plan:
- Reset then streaming: rst 2 cycles; then in_valid=1 with ctrl=0x0001..0x0005, data=1..5, out_ready=1.
  - Expect in_ready=1 throughout.
  - Expect out_valid from the cycle after the first accept, values 1..5 on consecutive cycles, occupancy=1.
- Backpressure fill: out_ready=0, send beats A=0x11, B=0x22, C=0x33.
  - Expect A, B accepted; occupancy 1 then 2; in_ready=0; C held upstream.
  - Expect out_data=0x11 stable and stall_cnt incrementing each cycle.
  - Raise out_ready: outputs 0x11, 0x22, 0x33 in order, with in_ready returning 1 one cycle after the first pop.
- Flush while FULL with simultaneous in_valid and pop.
  - Expect the current beat transferred that cycle.
  - Next cycle: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, and the offered beat is absent.
- Flush vs rst priority: assert both with 2 entries held.
  - Expect out_data=0 and stall_cnt=0 (rst semantics).
  - A repeat with flush alone leaves stall_cnt unchanged and out_data holding its old value while out_ctrl=0.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles.
  - Expect stall_cnt=15 from cycle 15 onward, with no wrap to 0.
- Randomised valid/ready, 10k beats, scoreboard compare.
  - Expect no loss, duplication or reorder.
  - Expect occupancy never 3 and in_ready never 1 while occupancy=2.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake over a main entry plus a skid entry,
// with synchronous flush (ctrl cleared to a bubble, data held) and a saturating stall counter.
module pipe_stage_elastic #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State is encoded by the valid bits {skid, main}; skid is never valid without main.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } stateT;

  logic              mainValidQ, mainValidD;
  logic              skidValidQ, skidValidD;
  logic [CTRL_W-1:0] mainCtrlQ, mainCtrlD;
  logic [CTRL_W-1:0] skidCtrlQ, skidCtrlD;
  logic [DATA_W-1:0] mainDataQ, mainDataD;
  logic [DATA_W-1:0] skidDataQ, skidDataD;
  logic [CNT_W-1:0]  stallCntQ, stallCntD;
  stateT             state;
  logic              acc;
  logic              pop;

  assign state     = stateT'({skidValidQ, mainValidQ});
  assign in_ready  = ~skidValidQ;
  assign out_valid = mainValidQ;
  assign out_ctrl  = mainValidQ ? mainCtrlQ : '0;
  assign out_data  = mainDataQ;
  assign occupancy = {skidValidQ, mainValidQ & ~skidValidQ};
  assign stall_cnt = stallCntQ;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mainValidD = mainValidQ;
    skidValidD = skidValidQ;
    mainCtrlD  = mainCtrlQ;
    skidCtrlD  = skidCtrlQ;
    mainDataD  = mainDataQ;
    skidDataD  = skidDataQ;
    stallCntD  = stallCntQ;

    unique case (state)
      StEmpty: begin
        if (acc) begin
          mainValidD = 1'b1;
          mainCtrlD  = in_ctrl;
          mainDataD  = in_data;
        end
      end
      StOne: begin
        if (acc && pop) begin
          mainCtrlD = in_ctrl;
          mainDataD = in_data;
        end else if (acc) begin
          skidValidD = 1'b1;
          skidCtrlD  = in_ctrl;
          skidDataD  = in_data;
        end else if (pop) begin
          mainValidD = 1'b0;
        end
      end
      default: begin
        if (pop) begin
          mainCtrlD  = skidCtrlQ;
          mainDataD  = skidDataQ;
          skidValidD = 1'b0;
        end
      end
    endcase

    // Flush squashes to a bubble; a pop this cycle has already transferred downstream.
    if (flush) begin
      mainValidD = 1'b0;
      skidValidD = 1'b0;
      mainCtrlD  = '0;
      skidCtrlD  = '0;
      mainDataD  = mainDataQ;
      skidDataD  = skidDataQ;
    end

    if (mainValidQ && !out_ready && (stallCntQ != '1)) begin
      stallCntD = stallCntQ + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mainValidQ <= 1'b0;
      skidValidQ <= 1'b0;
      mainCtrlQ  <= '0;
      skidCtrlQ  <= '0;
      mainDataQ  <= '0;
      skidDataQ  <= '0;
      stallCntQ  <= '0;
    end else begin
      mainValidQ <= mainValidD;
      skidValidQ <= skidValidD;
      mainCtrlQ  <= mainCtrlD;
      skidCtrlQ  <= skidCtrlD;
      mainDataQ  <= mainDataD;
      skidDataQ  <= skidDataD;
      stallCntQ  <= stallCntD;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and randomised checks of pipe_stage_elastic; a second narrow instance
// exercises stall counter saturation.
module tb_pipe_stage_elastic;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [15:0]  in_ctrl, out_ctrl;
  logic [127:0] in_data, out_data;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cnt;

  logic         sFlush, sInValid, sInReady, sOutValid, sOutReady;
  logic [3:0]   sInCtrl, sOutCtrl;
  logic [7:0]   sInData, sOutData;
  logic [1:0]   sOccupancy;
  logic [3:0]   sStallCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_elastic #(.CTRL_W(4), .DATA_W(8), .CNT_W(4)) sdut (
    .clk       (clk),
    .rst       (rst),
    .flush     (sFlush),
    .in_valid  (sInValid),
    .in_ready  (sInReady),
    .in_ctrl   (sInCtrl),
    .in_data   (sInData),
    .out_valid (sOutValid),
    .out_ready (sOutReady),
    .out_ctrl  (sOutCtrl),
    .out_data  (sOutData),
    .occupancy (sOccupancy),
    .stall_cnt (sStallCnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    sFlush = 1'b0; sInValid = 1'b0; sOutReady = 1'b0; sInCtrl = '0; sInData = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b occ=%0d, want 1 0 0",
               in_ready, out_valid, occupancy);
    end
    checks++;
    if (out_ctrl !== 16'h0 || out_data !== 128'h0 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_vals: ctrl=%h data=%h stall=%0d, want 0 0 0",
               out_ctrl, out_data, stall_cnt);
    end
  endtask

  task automatic test_streaming;
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_ctrl = 16'(i); in_data = 128'(i);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      if (i > 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'(i - 1) || out_data !== 128'(i - 1)
            || occupancy !== 2'd1) begin
          errors++;
          $display("FAIL stream_out[%0d]: v=%b ctrl=%h data=%0d occ=%0d want 1 %h %0d 1",
                   i, out_valid, out_ctrl, out_data, occupancy, 16'(i - 1), i - 1);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 16'h5 || out_data !== 128'd5) begin
      errors++;
      $display("FAIL stream_last: v=%b ctrl=%h data=%0d want 1 0005 5",
               out_valid, out_ctrl, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stream_drain: v=%b occ=%0d stall=%0d want 0 0 0",
               out_valid, occupancy, stall_cnt);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h11; in_data = 128'h11;
    tick();
    in_ctrl = 16'h22; in_data = 128'h22;
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 2'd1 || out_data !== 128'h11 || stall_cnt !== 16'd0)
    begin
      errors++;
      $display("FAIL bp_one: rdy=%b occ=%0d data=%h stall=%0d want 1 1 11 0",
               in_ready, occupancy, out_data, stall_cnt);
    end
    tick();
    in_ctrl = 16'h33; in_data = 128'h33;
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== 128'h11 || stall_cnt !== 16'd1)
    begin
      errors++;
      $display("FAIL bp_full: rdy=%b occ=%0d data=%h stall=%0d want 0 2 11 1",
               in_ready, occupancy, out_data, stall_cnt);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== 128'h11 ||
        out_ctrl !== 16'h11 || stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL bp_hold: rdy=%b occ=%0d data=%h ctrl=%h stall=%0d want 0 2 11 11 2",
               in_ready, occupancy, out_data, out_ctrl, stall_cnt);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 128'h22 || out_ctrl !== 16'h22 || in_ready !== 1'b1 || occupancy !== 2'd1)
    begin
      errors++;
      $display("FAIL bp_pop1: data=%h ctrl=%h rdy=%b occ=%0d want 22 22 1 1",
               out_data, out_ctrl, in_ready, occupancy);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 128'h33 || out_valid !== 1'b1 || occupancy !== 2'd1 || stall_cnt !== 16'd2)
    begin
      errors++;
      $display("FAIL bp_pop2: data=%h v=%b occ=%0d stall=%0d want 33 1 1 2",
               out_data, out_valid, occupancy, stall_cnt);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL bp_empty: v=%b occ=%0d want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush_full;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h44; in_data = 128'h44;
    tick();
    in_ctrl = 16'h55; in_data = 128'h55;
    tick();
    in_ctrl = 16'h66; in_data = 128'h66;
    out_ready = 1'b1; flush = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 128'h44 || occupancy !== 2'd2 || stall_cnt !== 16'd3)
    begin
      errors++;
      $display("FAIL flush_pre: v=%b data=%h occ=%0d stall=%0d want 1 44 2 3",
               out_valid, out_data, occupancy, stall_cnt);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
        out_data !== 128'h44 || stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL flush_post: v=%b ctrl=%h occ=%0d rdy=%b data=%h stall=%0d want 0 0 0 1 44 3",
               out_valid, out_ctrl, occupancy, in_ready, out_data, stall_cnt);
    end
    // Flush while EMPTY with an accepted beat: the beat must be dropped.
    in_valid = 1'b1; in_ctrl = 16'h67; in_data = 128'h67; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 128'h44) begin
      errors++;
      $display("FAIL flush_acc: v=%b occ=%0d data=%h want 0 0 44", out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_rst_priority;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h77; in_data = 128'h77;
    tick();
    in_ctrl = 16'h88; in_data = 128'h88;
    tick();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2 || stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL rp_fill: occ=%0d stall=%0d want 2 4", occupancy, stall_cnt);
    end
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    checks++;
    if (out_data !== 128'h0 || stall_cnt !== 16'd0 || occupancy !== 2'd0 || out_ctrl !== 16'h0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rp_rst: data=%h stall=%0d occ=%0d ctrl=%h rdy=%b want 0 0 0 0 1",
               out_data, stall_cnt, occupancy, out_ctrl, in_ready);
    end
    in_valid = 1'b1; in_ctrl = 16'h99; in_data = 128'h99;
    tick();
    in_ctrl = 16'hAA; in_data = 128'hAA;
    tick();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2 || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rp_refill: occ=%0d stall=%0d want 2 1", occupancy, stall_cnt);
    end
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (stall_cnt !== 16'd1 || out_data !== 128'h99 || out_ctrl !== 16'h0 ||
        out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL rp_flush: stall=%0d data=%h ctrl=%h v=%b occ=%0d want 1 99 0 0 0",
               stall_cnt, out_data, out_ctrl, out_valid, occupancy);
    end
  endtask

  task automatic test_saturation;
    sInValid = 1'b1; sInCtrl = 4'h1; sInData = 8'h5A; sOutReady = 1'b0;
    tick();
    sInValid = 1'b0;
    checks++;
    if (sOutValid !== 1'b1 || sStallCnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_start: v=%b stall=%0d want 1 0", sOutValid, sStallCnt);
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (sStallCnt !== 4'((k > 15) ? 15 : k) || sOutData !== 8'h5A) begin
        errors++;
        $display("FAIL sat[%0d]: stall=%0d data=%h want %0d 5a",
                 k, sStallCnt, sOutData, (k > 15) ? 15 : k);
      end
    end
  endtask

  task automatic test_random;
    logic [127:0] q[$];
    logic [127:0] exp;
    int           occ = 0;
    int           sent = 0;
    int           got = 0;
    int           cyc = 0;
    bit           acc, pop;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    while (got < 10000 && cyc < 60000 && errors < 20) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {32'(sent), ~32'(sent), 32'(sent) * 32'd7, 32'hC0DE0000 | 32'(sent)};
      in_ctrl   = 16'((sent % 65535) + 1);
      acc = in_valid && (occ != 2);
      pop = (occ != 0) && out_ready;
      checks++;
      if (in_ready !== (occ != 2) || out_valid !== (occ != 0) || occupancy !== 2'(occ)) begin
        errors++;
        $display("FAIL rnd_state@%0d: rdy=%b v=%b occ=%0d want occ %0d", cyc,
                 in_ready, out_valid, occupancy, occ);
      end
      if (pop) begin
        exp = q.pop_front();
        checks++;
        if (out_data !== exp || out_ctrl !== 16'((exp[127:96] % 65535) + 1)) begin
          errors++;
          $display("FAIL rnd_data@%0d: data=%h ctrl=%h want %h", cyc, out_data, out_ctrl, exp);
        end
        got++;
        occ--;
      end
      if (acc) begin
        q.push_back(in_data);
        sent++;
        occ++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 10000 || q.size() != 0) begin
      errors++;
      $display("FAIL rnd_total: got %0d beats, %0d left, want 10000 and 0", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_rst_priority();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
